// File: rtl/ddr_tx_serializer_if.sv
// Parallel-word handshake plus the O_DDR / O_BUFT_DS drive signals
// of the DDR transmit serializer.
interface ddr_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [1:0]            ddr_d;
    logic                  ddr_en;
    logic                  oe;
    logic                  word_done;
    logic                  busy;

    modport master (
        output s_data, s_valid,
        input  s_ready, ddr_d, ddr_en, oe, word_done, busy
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, ddr_d, ddr_en, oe, word_done, busy
    );
endinterface

// File: rtl/ddr_tx_serializer.sv
// Serializes parallel words 2 bits per clock for O_DDR, framing each
// burst with preamble and tail beats and driving the pad enable.
module ddr_tx_serializer #(
    parameter int DATA_WIDTH      = 8,
    parameter int PREAMBLE_CYCLES = 2,
    parameter int TAIL_CYCLES     = 1
) (
    input logic                clk,
    input logic                rst,
    ddr_tx_serializer_if.slave bus
);
    localparam int BEATS  = DATA_WIDTH / 2;
    localparam int MAX_PT = (PREAMBLE_CYCLES > TAIL_CYCLES) ?
                            PREAMBLE_CYCLES : TAIL_CYCLES;
    localparam int MAXB   = (BEATS > MAX_PT) ? BEATS : MAX_PT;
    localparam int CW     = $clog2(MAXB + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        SHIFT = 2'd2,
        TAIL  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [1:0]            ddr_d_q, ddr_d_d;
    logic                  en_q, en_d;
    logic                  wd_q, wd_d;
    logic                  take;
    logic                  consume;
    logic                  last_pre;
    logic                  last_beat;
    logic                  last_tail;

    assign bus.s_ready = ~hold_valid_q & ~rst;
    assign take        = bus.s_valid & bus.s_ready;

    // take needs hold empty, consume needs it full: never both
    assign hold_valid_d = take | (hold_valid_q & ~consume);

    assign last_pre  = (cnt_q == CW'(PREAMBLE_CYCLES - 1));
    assign last_beat = (cnt_q == CW'(BEATS - 1));
    assign last_tail = (cnt_q == CW'(TAIL_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hold_valid_q <= 1'b0;
            ddr_d_q      <= 2'b00;
            en_q         <= 1'b0;
            wd_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_valid_q <= hold_valid_d;
            ddr_d_q      <= ddr_d_d;
            en_q         <= en_d;
            wd_q         <= wd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            hold_q <= bus.s_data;
        end
        sr_q <= sr_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        consume = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    consume = 1'b1;
                end
            end
            PRE: begin
                if (last_pre) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (last_beat) begin
                    cnt_d = '0;
                    if (hold_valid_q) begin
                        consume = 1'b1;
                    end else begin
                        state_d = TAIL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TAIL: begin
                if (last_tail) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Shift register keeps the next beat in its low pair
    always_comb begin
        sr_d    = sr_q;
        ddr_d_d = 2'b00;
        en_d    = 1'b0;
        wd_d    = 1'b0;
        unique case (state_d)
            IDLE: begin
            end
            PRE: begin
                en_d    = 1'b1;
                ddr_d_d = 2'b10;
                if (consume) begin
                    sr_d = hold_q;
                end
            end
            SHIFT: begin
                en_d = 1'b1;
                wd_d = (cnt_d == CW'(BEATS - 1));
                if (consume) begin
                    ddr_d_d = hold_q[1:0];
                    sr_d    = hold_q >> 2;
                end else begin
                    ddr_d_d = sr_q[1:0];
                    sr_d    = sr_q >> 2;
                end
            end
            TAIL: begin
                en_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.ddr_d     = ddr_d_q;
    assign bus.ddr_en    = en_q;
    assign bus.oe        = en_q;
    assign bus.word_done = wd_q;
    assign bus.busy      = (state_q != IDLE) | hold_valid_q;
endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Bench for ddr_tx_serializer: beat-queue reference model checked every
// cycle, directed framing sequences, then randomized traffic with resets.
module tb_ddr_tx_serializer;
    localparam int DW  = 8;
    localparam int PRE = 2;
    localparam int TL  = 1;
    localparam int NB  = DW / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ddr_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

    ddr_tx_serializer #(
        .DATA_WIDTH     (DW),
        .PREAMBLE_CYCLES(PRE),
        .TAIL_CYCLES    (TL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of the output beats still owed
    typedef struct packed {
        logic [1:0] d;
        logic       en;
        logic       wd;
    } beat_t;

    beat_t          bq[$];
    beat_t          shown = '0;
    logic [DW-1:0]  m_hold = '0;
    bit             m_hv   = 1'b0;
    bit             m_take = 1'b0;
    bit             m_live = 1'b0;

    function automatic void queue_word(input logic [DW-1:0] w);
        beat_t b;
        for (int k = 0; k < NB; k++) begin
            b.d  = w[2*k +: 2];
            b.en = 1'b1;
            b.wd = (k == NB - 1);
            bq.push_back(b);
        end
    endfunction

    function automatic void queue_fill(input logic [1:0] d, input int n);
        beat_t b;
        b.d  = d;
        b.en = 1'b1;
        b.wd = 1'b0;
        for (int k = 0; k < n; k++) bq.push_back(b);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            bq.delete();
            m_hv   = 1'b0;
            m_take = 1'b0;
            shown  = '0;
            m_live = 1'b1;
        end else begin
            m_take = bus.s_valid && !m_hv;
            if (bq.size() == 0) begin
                if (shown.wd && m_hv) begin
                    queue_word(m_hold);
                    m_hv = 1'b0;
                end else if (shown.wd) begin
                    queue_fill(2'b00, TL);
                end else if (!shown.en && m_hv) begin
                    queue_fill(2'b10, PRE);
                    queue_word(m_hold);
                    m_hv = 1'b0;
                end
            end
            if (bq.size() > 0) shown = bq.pop_front();
            else shown = '0;
            if (m_take) begin
                m_hold = bus.s_data;
                m_hv   = 1'b1;
            end
        end
    end

    logic [1:0] log_d  [0:4095];
    logic       log_oe [0:4095];
    logic       log_wd [0:4095];

    always @(negedge clk) begin
        if (cyc < 4096) begin
            log_d[cyc]  = bus.ddr_d;
            log_oe[cyc] = bus.oe;
            log_wd[cyc] = bus.word_done;
        end
        if (m_live) begin
            chk("ddr_d",     32'(bus.ddr_d),     32'(shown.d));
            chk("ddr_en",    32'(bus.ddr_en),    32'(shown.en));
            chk("oe",        32'(bus.oe),        32'(shown.en));
            chk("word_done", 32'(bus.word_done), 32'(shown.wd));
            chk("s_ready",   32'(bus.s_ready),   32'(!m_hv && !rst));
            chk("busy",      32'(bus.busy),      32'(shown.en || m_hv));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w, output int acc);
        int n = 0;
        bus.s_data  = w;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && n < 50) begin
            step();
            n++;
        end
        chk("push_ready", 32'(bus.s_ready), 32'd1);
        step();
        acc = cyc;
    endtask

    logic [1:0] exp1 [7]  = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0};
    logic [1:0] exp2 [11] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd2,
                              2'd2, 2'd3, 2'd1, 2'd0, 2'd0};
    logic [1:0] exp4 [7]  = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, c;
        bit fire;
        int dens;

        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAA;
        rst         = 1'b1;
        repeat (3) step();
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_oe",      32'(bus.oe),      32'd0);
        chk("rst_ddr_en",  32'(bus.ddr_en),  32'd0);
        chk("rst_ddr_d",   32'(bus.ddr_d),   32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        bus.s_valid = 1'b0;
        rst         = 1'b0;
        step();
        chk("rst_no_capture", 32'(bus.busy), 32'd0);

        push(8'hB4, a);
        bus.s_valid = 1'b0;
        repeat (9) step();
        for (int i = 0; i < 7; i++) begin
            chk("single_d",  32'(log_d[a+1+i]),  32'(exp1[i]));
            chk("single_oe", 32'(log_oe[a+1+i]), 32'd1);
            chk("single_wd", 32'(log_wd[a+1+i]), 32'(i == 5));
        end
        chk("single_oe_off", 32'(log_oe[a+8]), 32'd0);
        chk("single_busy",   32'(bus.busy),    32'd0);

        push(8'hB4, a);
        push(8'h1E, b);
        bus.s_valid = 1'b0;
        repeat (14) step();
        for (int i = 0; i < 11; i++) begin
            chk("b2b_d",  32'(log_d[a+1+i]),  32'(exp2[i]));
            chk("b2b_oe", 32'(log_oe[a+1+i]), 32'd1);
            chk("b2b_wd", 32'(log_wd[a+1+i]), 32'(i == 5 || i == 9));
        end
        chk("b2b_oe_off", 32'(log_oe[a+12]), 32'd0);

        push(8'hB4, a);
        bus.s_valid = 1'b0;
        repeat (6) step();
        push(8'h5A, b);
        bus.s_valid = 1'b0;
        repeat (16) step();
        chk("tailw_tail_d",  32'(log_d[a+7]),  32'd0);
        chk("tailw_tail_oe", 32'(log_oe[a+7]), 32'd1);
        chk("tailw_idle_oe", 32'(log_oe[a+8]), 32'd0);
        chk("tailw_idle_d",  32'(log_d[a+8]),  32'd0);
        chk("tailw_pre0",    32'(log_d[a+9]),  32'd2);
        chk("tailw_pre1",    32'(log_d[a+10]), 32'd2);
        chk("tailw_pre_oe",  32'(log_oe[a+9]), 32'd1);
        chk("tailw_data0",   32'(log_d[a+11]), 32'd2);

        push(8'hB4, a);
        push(8'h77, b);
        bus.s_valid = 1'b0;
        repeat (2) step();
        chk("rstmid_beat1", 32'(bus.ddr_d), 32'd1);
        rst         = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h66;
        step();
        chk("rstmid_d",       32'(bus.ddr_d),     32'd0);
        chk("rstmid_oe",      32'(bus.oe),        32'd0);
        chk("rstmid_en",      32'(bus.ddr_en),    32'd0);
        chk("rstmid_wd",      32'(bus.word_done), 32'd0);
        chk("rstmid_busy",    32'(bus.busy),      32'd0);
        chk("rstmid_s_ready", 32'(bus.s_ready),   32'd0);
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        step();
        chk("rstmid_hold_empty", 32'(bus.busy), 32'd0);
        push(8'h0F, b);
        bus.s_valid = 1'b0;
        repeat (9) step();
        for (int i = 0; i < 7; i++) begin
            chk("rstmid_new_d",  32'(log_d[b+1+i]),  32'(exp4[i]));
            chk("rstmid_new_wd", 32'(log_wd[b+1+i]), 32'(i == 5));
        end

        push(8'h11, a);
        push(8'h22, b);
        push(8'h33, c);
        bus.s_valid = 1'b0;
        repeat (30) step();

        dens = 60;
        fire = 1'b0;
        bus.s_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dens = int'($urandom_range(5, 100));
            if (!bus.s_valid || fire) begin
                bus.s_valid = ($urandom_range(0, 99) < dens);
                bus.s_data  = DW'($urandom);
            end
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            step();
            fire = m_take;
        end
        bus.s_valid = 1'b0;
        rst         = 1'b0;
        repeat (30) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ddr_tx_serializer.md
Name: ddr_tx_serializer

Overview:
- Upstream feeder for the O_DDR / O_BUFT_DS output path.
- Accepts DATA_WIDTH-bit parallel words on a valid/ready handshake and emits them 2 bits per clk on ddr_d, which connects to the O_DDR D input.
- Generates the O_DDR enable (ddr_en) and the tristate drive control (oe) that goes to the O_BUFT_DS T input.
- Frames each burst as preamble, then data, then tail, and idles with the pad released.

Parameters:
- DATA_WIDTH, 8: word width; must be even and >= 4.
- PREAMBLE_CYCLES, 2: preamble beats (ddr_d=2'b10) before the first word of a burst; must be >= 1.
- TAIL_CYCLES, 1: tail beats (ddr_d=2'b00) after the last word of a burst; must be >= 1.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- s_data  input  DATA_WIDTH  word to transmit.
- s_valid  input  1  s_data valid.
- s_ready  output  1  holding register free; combinational = ~hold_valid & ~rst.
- ddr_d  output  2  pair to O_DDR D; bit0 = first bit of the pair.
- ddr_en  output  1  O_DDR E.
- oe  output  1  pad drive enable to O_BUFT_DS T; 1 = drive.
- word_done  output  1  one-cycle pulse on the last data beat of each word.
- busy  output  1  state != IDLE or hold_valid.

Behaviour:
- ddr_d, ddr_en, oe and word_done are registered.
- Reset values: ddr_d=0, ddr_en=0, oe=0, word_done=0, state=IDLE, hold_valid=0, beat counter=0.
- Reset mid-burst takes effect at the next edge with the values above. Any held or partially sent word is dropped. s_ready is 0 while rst=1.
- Holding register (1 entry): a transfer occurs when s_valid & s_ready at an edge; s_data is captured into hold and hold_valid is set.
- The FSM consumes hold by copying it into the shift register and clearing hold_valid at the same edge. The FSM is the only consumer, so capture and consume never coincide.
- IDLE: oe=0, ddr_en=0, ddr_d=0. If hold_valid, go to PREAMBLE, load hold into the shift register, and set beat counter=0.
- Latency: a word accepted at edge E0 gives the first preamble beat on the outputs after E1.
- PREAMBLE: oe=1, ddr_en=1, ddr_d=2'b10 for exactly PREAMBLE_CYCLES cycles, then SHIFT.
- SHIFT: oe=1, ddr_en=1. Runs DATA_WIDTH/2 beats, LSB-first: beat k drives ddr_d = {sr[2k+1], sr[2k]}.
- word_done=1 on the final SHIFT beat (k = DATA_WIDTH/2-1).
- At the final SHIFT beat:
  - if hold_valid, reload the shift register from hold and stay in SHIFT with k=0. There is no gap and no preamble, so a back-to-back burst is continuous.
  - otherwise go to TAIL.
- TAIL: oe=1, ddr_en=1, ddr_d=2'b00 for TAIL_CYCLES cycles, then IDLE. A word arriving during TAIL waits; after TAIL the block goes to IDLE for 1 cycle, then starts a new PREAMBLE.
- oe never deasserts inside a burst. oe and ddr_en are always equal.
- The beat counter is sized ceil(log2(max(DATA_WIDTH/2, PREAMBLE_CYCLES, TAIL_CYCLES)+1)). It wraps only by explicit reload, never by overflow.
- s_valid with s_ready=0: the source holds s_data and s_valid stable. The block does not sample s_data.

Test Plan:
- Reset: rst=1 for 3 cycles with s_valid=1 -> s_ready=0, oe=0, ddr_en=0, ddr_d=0, busy=0; no word is captured.
- Single word 0xB4 (DATA_WIDTH=8, PREAMBLE=2, TAIL=1), accepted at E0 -> after E1: ddr_d sequence 10,10,00,01,11,10,00 (7 cycles) with oe=ddr_en=1 throughout; word_done high only on the 11→10 beat (the 4th data beat, ddr_d=10); then oe=0 and busy=0.
- Back-to-back 0xB4 then 0x1E, second word presented while the first is in PREAMBLE -> 10,10,00,01,11,10,10,11,01,00,00. One preamble, one tail, oe continuous, word_done pulses twice.
- Word presented during TAIL -> after TAIL there is 1 IDLE cycle with oe=0, then a fresh 2-cycle preamble.
- Reset asserted on the 2nd data beat of 0xB4 -> after the next edge all outputs are 0 and hold is empty. After release, a new word 0x0F sends 10,10,11,11,00,00,00 correctly.
- Backpressure: s_valid held high across 3 words with hold full -> s_ready low while hold_valid=1, no word lost or duplicated, and the output order matches the input order.
